// File: rtl/aes_pkg.sv
// Shared AES types, round-count constant and round-constant lookup.
package aes_pkg;

    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam int unsigned AES_WORD_W     = 32;
    localparam int unsigned AES_BLOCK_W    = 128;

    typedef logic [AES_WORD_W-1:0]  aes_word_t;
    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } aes_ks_state_t;

    // Round constant used to derive round key idx+1 from round key idx.
    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    // Row-major table: entry 0 occupies the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_hi;

    assign bit_hi = 11'h7ff - {data, 3'b000};
    assign subst  = SBOX_TABLE[bit_hi -: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule streaming round keys 0..10 over a valid/ready handshake.
// Define AES_KEY_CACHE_EN to add an 11-entry round-key cache with a random-access read port.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
`ifdef AES_KEY_CACHE_EN
    ,
    input  logic [3:0]   cache_idx,
    output logic [127:0] cache_key
`endif
);

    if (NUM_ROUNDS != AES_NUM_ROUNDS) begin : g_bad_rounds
        $error("aes_key_expand: NUM_ROUNDS must be %0d", AES_NUM_ROUNDS);
    end

    localparam logic [3:0] LAST_IDX = 4'(AES_NUM_ROUNDS);

    aes_ks_state_t state;
    aes_word_t     w0, w1, w2, w3;
    aes_word_t     rot_w, sub_w, t_w;
    aes_word_t     n0, n1, n2, n3;
    aes_block_t    next_key;
    logic [3:0]    next_idx;

    // next_key(): RotWord -> SubWord -> Rcon, then the running XOR across words.
    assign {w0, w1, w2, w3} = rk_data;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .data  (rot_w[8*i +: 8]),
            .subst (sub_w[8*i +: 8])
        );
    end

    assign t_w      = sub_w ^ {aes_rcon(rk_idx), 24'h000000};
    assign n0       = w0 ^ t_w;
    assign n1       = n0 ^ w1;
    assign n2       = n1 ^ w2;
    assign n3       = n2 ^ w3;
    assign next_key = {n0, n1, n2, n3};
    assign next_idx = rk_idx + 4'd1;

`ifdef AES_KEY_CACHE_EN
    aes_block_t cache_mem [0:AES_NUM_ROUNDS];

    assign cache_key = (cache_idx <= LAST_IDX) ? cache_mem[cache_idx] : '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_idx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            for (int i = 0; i <= int'(AES_NUM_ROUNDS); i++) begin
                cache_mem[i] <= '0;
            end
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk_data  <= key_in;
                        rk_idx   <= '0;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= EXPAND;
`ifdef AES_KEY_CACHE_EN
                        cache_mem[0] <= key_in;
`endif
                    end
                end
                EXPAND: begin
                    // rk_data/rk_idx/rk_valid hold unless the consumer takes the key.
                    if (rk_valid && rk_ready) begin
                        if (rk_idx == LAST_IDX) begin
                            rk_valid <= 1'b0;
                            rk_idx   <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            rk_data <= next_key;
                            rk_idx  <= next_idx;
`ifdef AES_KEY_CACHE_EN
                            cache_mem[next_idx] <= next_key;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
